ts_width_conv_fifo: RTL and testbench



---
 rtl/ts_wconv_pkg.sv | 14 +
 rtl/ts_wconv_ram.sv | 28 ++
 rtl/ts_width_conv_fifo.sv | 159 +++++++++++++++
 tb/tb_ts_width_conv_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ts_wconv_pkg.sv
// Shared constants and helpers for the TS width-converting FIFO.
package ts_wconv_pkg;

   localparam int LANE_W = 32;

   function automatic logic [LANE_W-1:0] bswap32(input logic [LANE_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic bit ratio_legal(input int r);
      return (r == 2) || (r == 4) || (r == 8);
   endfunction

endpackage

// File: rtl/ts_wconv_ram.sv
// Simple dual-port RAM: one write port, one registered synchronous read port.
// Storage is not reset; the read register is only consumed when a read was issued.
module ts_wconv_ram #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ts_width_conv_fifo.sv
// Packs 32-bit TS words into RATIO-lane words and buffers them for the DMA side.
// Optional macro TS_BYTE_SWAP_EN: byte-reverse every lane on the way out.
module ts_width_conv_fifo
   import ts_wconv_pkg::*;
#(
   parameter int RATIO = 4,
   parameter int DEPTH = 512
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [LANE_W-1:0]             wr_data,
   input  logic                          flush,
   output logic                          full,
   input  logic                          rd_en,
   output logic [LANE_W*RATIO-1:0]       rd_data,
   output logic                          rd_valid,
   output logic                          empty,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = $clog2(DEPTH+1);
   localparam int WL_W = $clog2(RATIO);
   localparam int OW   = LANE_W*RATIO;

   if (!ratio_legal(RATIO)) begin : g_bad_ratio
      $error("ts_width_conv_fifo: RATIO must be 2, 4 or 8");
   end
   if ((DEPTH < 4) || ((DEPTH & (DEPTH-1)) != 0)) begin : g_bad_depth
      $error("ts_width_conv_fifo: DEPTH must be a power of 2 and >= 4");
   end

   logic [WL_W-1:0]                    wl_q, wl_d;
   logic [RATIO-2:0][LANE_W-1:0]       staging_q, staging_d;
   logic [AW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]                      level_q, level_d;
   logic                               overflow_q, overflow_d;
   logic                               underflow_q, underflow_d;
   logic                               rd_pend_q, rd_pend_d;
   logic                               rd_valid_q, rd_valid_d;
   logic [OW-1:0]                      rd_data_q, rd_data_d;

   logic                               wr_acc, rd_acc, lane_last, flush_do, commit;
   logic [OW-1:0]                      commit_word, mem_rdata, rd_word;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

   // write-side packing, commit/flush decision, pointers, level and sticky flags
   always_comb begin
      wr_acc    = wr_en && !full;
      rd_acc    = rd_en && !empty;
      lane_last = (wl_q == WL_W'(RATIO-1));
      flush_do  = flush && !full && ((wl_q != '0) || wr_en);
      commit    = (wr_acc && lane_last) || flush_do;

      // lanes above the fill point are stale staging contents, so mask them to zero
      commit_word = '0;
      for (int k = 0; k < RATIO-1; k++) begin
         if (wr_acc && (wl_q == WL_W'(k)))
            commit_word[k*LANE_W +: LANE_W] = wr_data;
         else if (WL_W'(k) < wl_q)
            commit_word[k*LANE_W +: LANE_W] = staging_q[k];
      end
      if (wr_acc && lane_last)
         commit_word[(RATIO-1)*LANE_W +: LANE_W] = wr_data;

      staging_d = staging_q;
      for (int k = 0; k < RATIO-1; k++) begin
         if (wr_acc && (wl_q == WL_W'(k))) staging_d[k] = wr_data;
      end

      wl_d = wl_q;
      if (commit)      wl_d = '0;
      else if (wr_acc) wl_d = wl_q + WL_W'(1);

      wptr_d = commit ? wptr_q + AW'(1) : wptr_q;
      rptr_d = rd_acc ? rptr_q + AW'(1) : rptr_q;

      level_d = level_q;
      case ({commit, rd_acc})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      overflow_d  = overflow_q  || (wr_en && full);
      underflow_d = underflow_q || (rd_en && empty);
   end

   ts_wconv_ram #(
      .WIDTH (OW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (commit),
      .waddr (wptr_q),
      .wdata (commit_word),
      .re    (rd_acc),
      .raddr (rptr_q),
      .rdata (mem_rdata)
   );

`ifdef TS_BYTE_SWAP_EN
   // per-lane byte reversal for PCIe ordering; lane positions are kept
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < RATIO; k++)
         rd_word[k*LANE_W +: LANE_W] = bswap32(mem_rdata[k*LANE_W +: LANE_W]);
   end
`else
   assign rd_word = mem_rdata;
`endif

   // output register loads only when a read is in flight, otherwise holds
   always_comb begin
      rd_pend_d  = rd_acc;
      rd_valid_d = rd_pend_q;
      rd_data_d  = rd_pend_q ? rd_word : rd_data_q;
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wl_q        <= '0;
         staging_q   <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wl_q        <= wl_d;
         staging_q   <= staging_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_pend_q   <= rd_pend_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ts_width_conv_fifo.sv
// Directed bench for ts_width_conv_fifo (RATIO=4, DEPTH=4) with a scoreboard of committed words.
module tb_ts_width_conv_fifo;

   localparam int RATIO = 4;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_en, flush, rd_en;
   logic [31:0]  wr_data;
   logic         full, empty, rd_valid, overflow, underflow;
   logic [127:0] rd_data;
   logic [2:0]   level;

   ts_width_conv_fifo #(.RATIO(RATIO), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .full      (full),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int got_reads = 0;
   int exp_reads = 0;

   logic [31:0]  stage[$];
   logic [127:0] sb[$];
   int           mlevel = 0;
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;

   function automatic logic [31:0] bsw(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic push_word();
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < stage.size(); i++) begin
`ifdef TS_BYTE_SWAP_EN
         w[i*32 +: 32] = bsw(stage[i]);
`else
         w[i*32 +: 32] = stage[i];
`endif
      end
      sb.push_back(w);
      stage.delete();
   endtask

   // drive one cycle of inputs and advance the reference model
   task automatic drive(input logic we, input logic [31:0] wd, input logic fl, input logic re);
      logic fm, em, wacc, racc, cm;
      fm = (mlevel == DEPTH);
      em = (mlevel == 0);
      wr_en = we; wr_data = wd; flush = fl; rd_en = re;
      if (we && fm) m_ovf = 1'b1;
      if (re && em) m_unf = 1'b1;
      wacc = we && !fm;
      if (wacc) stage.push_back(wd);
      cm = (wacc && stage.size() == RATIO) || (fl && !fm && stage.size() != 0);
      if (cm) push_word();
      racc = re && !em;
      if (racc) exp_reads++;
      mlevel = mlevel + (cm ? 1 : 0) - (racc ? 1 : 0);
      @(posedge clk); #1;
      wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0;
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_level"}, level, mlevel);
      chk({tag, "_full"}, full, mlevel == DEPTH);
      chk({tag, "_empty"}, empty, mlevel == 0);
      chk({tag, "_ovf"}, overflow, m_ovf);
      chk({tag, "_unf"}, underflow, m_unf);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_data"}, rd_data, 128'h0);
      chk({tag, "_rd_valid"}, rd_valid, 1'b0);
      chk({tag, "_empty"}, empty, 1'b1);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_level"}, level, 3'd0);
      chk({tag, "_ovf"}, overflow, 1'b0);
      chk({tag, "_unf"}, underflow, 1'b0);
   endtask

   // scoreboard: every valid output word must match the oldest committed word
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         got_reads++;
         chk("sb_has_entry", 128'(sb.size() > 0), 128'(1));
         if (sb.size() > 0) chk("sb_word", rd_data, sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] e1, e2, e3;
`ifdef TS_BYTE_SWAP_EN
      e1 = 128'h00ffeedd_ccbbaa99_88776655_44332211;
      e2 = 128'h00000000_00000000_0200AAAA_0100AAAA;
      e3 = 128'h04000077_03000077_02000077_01000077;
`else
      e1 = 128'hddeeff00_99aabbcc_55667788_11223344;
      e2 = 128'h00000000_00000000_AAAA0002_AAAA0001;
      e3 = 128'h77000004_77000003_77000002_77000001;
`endif
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      rst_n = 1'b1;
      drive(0, 0, 0, 0);

      // basic pack of four words
      drive(1, 32'h11223344, 0, 0);
      drive(1, 32'h55667788, 0, 0);
      drive(1, 32'h99aabbcc, 0, 0);
      chk("pack_level_before", level, 3'd0);
      drive(1, 32'hddeeff00, 0, 0);
      chk_status("pack");
      drive(0, 0, 0, 1);
      chk("pack_rd_valid_lat", rd_valid, 1'b0);
      drive(0, 0, 0, 0);
      chk("pack_rd_valid", rd_valid, 1'b1);
      chk("pack_word", rd_data, e1);
      drive(0, 0, 0, 0);
      chk("pack_hold", rd_data, e1);

      // flush of a partial group, then a full group proves the lane counter restarted
      drive(1, 32'hAAAA0001, 0, 0);
      drive(1, 32'hAAAA0002, 0, 0);
      drive(0, 0, 1, 0);
      chk("flush_level", level, 3'd1);
      drive(0, 0, 1, 0);
      chk("flush_noop_level", level, 3'd1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("flush_word", rd_data, e2);
      for (int i = 1; i <= 4; i++) drive(1, 32'h77000000 + i, 0, 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("after_flush_word", rd_data, e3);
      drive(0, 0, 0, 0);

      // fill to full, overflow, drain in order
      for (int i = 0; i < 16; i++) drive(1, 32'h10000000 + i, 0, 0);
      chk("full_flag", full, 1'b1);
      chk("full_level", level, 3'd4);
      drive(1, 32'hDEADBEEF, 0, 0);
      chk("ovf_flag", overflow, 1'b1);
      drive(0, 0, 1, 0);
      chk_status("full");
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk_status("drained");

      // underflow
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("unf_rd_valid", rd_valid, 1'b0);
      drive(0, 0, 0, 0);
      chk("unf_flag", underflow, 1'b1);
      chk("unf_level", level, 3'd0);

      // simultaneous commit and read at level 2
      for (int i = 0; i < 8; i++) drive(1, 32'h20000000 + i, 0, 0);
      chk("sim_level_pre", level, 3'd2);
      for (int i = 8; i < 11; i++) drive(1, 32'h20000000 + i, 0, 0);
      drive(1, 32'h2000000B, 0, 1);
      chk("sim_level_post", level, 3'd2);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk_status("sim");

      // streaming across three pointer wraps
      for (int i = 0; i < 4*3*DEPTH; i++) drive(1, 32'h50000000 + i, 0, mlevel > 0);
      for (int i = 0; i < DEPTH && mlevel > 0; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk_status("stream");

      // reset in the middle of staging with two words buffered
      for (int i = 0; i < 8; i++) drive(1, 32'h60000000 + i, 0, 0);
      for (int i = 8; i < 11; i++) drive(1, 32'h60000000 + i, 0, 0);
      chk("mid_level", level, 3'd2);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      stage.delete(); sb.delete(); mlevel = 0; m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) drive(1, 32'h77000000 + i, 0, 0);
      chk("post_rst_level", level, 3'd1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("post_rst_word", rd_data, e3);
      drive(0, 0, 0, 0);

      chk("read_count", got_reads, exp_reads);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
